// File: rtl/vga_timing_pkg.sv
// Shared 640x480 timing constants, FSM state encoding and the 11-bit
// measurement type used by the VGA sync decoder.
package vga_timing_pkg;

  localparam int unsigned CNT_W = 11;
  typedef logic [CNT_W-1:0] count_t;
  localparam count_t CNT_MAX = '1;

  localparam int unsigned VGA_H_TOTAL      = 800;
  localparam int unsigned VGA_H_ACTIVE     = 640;
  localparam int unsigned VGA_H_SYNC_START = 659;
  localparam int unsigned VGA_H_SYNC_END   = 754;
  localparam int unsigned VGA_V_TOTAL      = 525;
  localparam int unsigned VGA_V_ACTIVE     = 480;
  localparam int unsigned VGA_V_SYNC_START = 493;
  localparam int unsigned VGA_V_SYNC_END   = 494;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } sync_state_e;

  function automatic count_t sat_inc(input count_t v, input logic en);
    return (en && (v != CNT_MAX)) ? v + count_t'(1) : v;
  endfunction

endpackage

// File: rtl/vga_period_meter.sv
// Saturating tick counter that captures its running count on each edge
// strobe; period_c exposes the value being captured this cycle.
module vga_period_meter
  import vga_timing_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   tick,
  input  logic   capture,
  output count_t period,
  output count_t period_c
);

  count_t count_q, count_d;
  count_t period_q, period_d;

  // A tick coinciding with the capture belongs to the period being closed.
  assign period_c = sat_inc(count_q, tick);

  always_comb begin
    count_d  = sat_inc(count_q, tick);
    period_d = period_q;
    if (capture) begin
      count_d  = '0;
      period_d = period_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      period_q <= '0;
    end else begin
      count_q  <= count_d;
      period_q <= period_d;
    end
  end

  assign period = period_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates from an HS/VS/BLANK_N stream, measures its timing
// and tracks lock. Optional error counter: VGA_SYNC_DECODER_STATS_EN.
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_TOTAL     = VGA_H_TOTAL,
  parameter int unsigned V_TOTAL     = VGA_V_TOTAL,
  parameter int unsigned H_ACTIVE    = VGA_H_ACTIVE,
  parameter int unsigned V_ACTIVE    = VGA_V_ACTIVE,
  parameter int unsigned LOCK_FRAMES = 2
)(
  input  logic        vga_clock,
  input  logic        reset,
  input  logic        VGA_HS,
  input  logic        VGA_VS,
  input  logic        VGA_BLANK_N,
  output logic [9:0]  xCoord,
  output logic [9:0]  yCoord,
  output logic        pixel_valid,
  output logic        frame_start,
  output logic        locked,
  output logic        timing_err,
  output logic [10:0] h_total,
  output logic [10:0] v_total,
  output logic [10:0] h_active,
  output logic [10:0] v_active,
  output logic [15:0] err_count
);

  logic in_hs_q, in_vs_q, in_blank_q, dly_hs_q, dly_vs_q, dly_blank_q;
  logic in_hs_d, in_vs_d, in_blank_d, dly_hs_d, dly_vs_d, dly_blank_d;
  logic hs_fall, vs_fall, blank_rise, blank_fall;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic pv_q, pv_d, fs_q, fs_d, locked_q, locked_d, terr_q, terr_d, h_ok_q, h_ok_d;
  count_t act_q, act_d, line_act_q, line_act_d, vact_q, vact_d;
  count_t h_active_q, h_active_d, v_active_q, v_active_d, gap_q, gap_d;
  count_t h_period, h_period_c, v_period, v_period_c, h_act_new, v_act_new;
  logic line_bad, frame_ok, timeout;
  sync_state_e state_q, state_d;
  logic [3:0] good_q, good_d, good_inc;

  assign hs_fall    = dly_hs_q & ~in_hs_q;
  assign vs_fall    = dly_vs_q & ~in_vs_q;
  assign blank_rise = in_blank_q & ~dly_blank_q;
  assign blank_fall = ~in_blank_q & dly_blank_q;

  vga_period_meter u_h_meter (
    .clk(vga_clock), .rst(reset), .tick(1'b1), .capture(hs_fall),
    .period(h_period), .period_c(h_period_c)
  );

  vga_period_meter u_v_meter (
    .clk(vga_clock), .rst(reset), .tick(hs_fall), .capture(vs_fall),
    .period(v_period), .period_c(v_period_c)
  );

  // Line/frame checks; a line closing on the VS edge still belongs to the old frame.
  assign line_bad  = hs_fall && (h_period_c != count_t'(H_TOTAL));
  assign h_act_new = blank_fall ? act_q : line_act_q;
  assign v_act_new = sat_inc(vact_q, blank_fall);
  assign frame_ok  = h_ok_q && !line_bad && (v_period_c == count_t'(V_TOTAL)) &&
                     (h_act_new == count_t'(H_ACTIVE)) && (v_act_new == count_t'(V_ACTIVE));
  assign timeout   = !hs_fall && (gap_q == count_t'(2 * H_TOTAL - 1));
  assign good_inc  = good_q + 4'd1;

  always_comb begin
    in_hs_d     = VGA_HS;
    in_vs_d     = VGA_VS;
    in_blank_d  = VGA_BLANK_N;
    dly_hs_d    = in_hs_q;
    dly_vs_d    = in_vs_q;
    dly_blank_d = in_blank_q;
    pv_d        = in_blank_q;
    fs_d        = vs_fall;
    x_d         = x_q;
    y_d         = y_q;
    if (in_blank_q) x_d = blank_rise ? 10'd0 : x_q + 10'd1;
    if (vs_fall) y_d = 10'd0;
    else if (blank_fall) y_d = y_q + 10'd1;
    act_d       = blank_rise ? count_t'(1) : sat_inc(act_q, in_blank_q);
    line_act_d  = blank_fall ? act_q : line_act_q;
    vact_d      = vs_fall ? '0 : v_act_new;
    h_active_d  = vs_fall ? h_act_new : h_active_q;
    v_active_d  = vs_fall ? v_act_new : v_active_q;
    gap_d       = hs_fall ? '0 : sat_inc(gap_q, 1'b1);
    h_ok_d      = vs_fall ? 1'b1 : (h_ok_q && !line_bad);
  end

  always_ff @(posedge vga_clock or posedge reset) begin
    if (reset) begin
      state_q <= HUNT;
      good_q  <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
    end
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    if (timeout) begin
      state_d = HUNT;
    end else begin
      case (state_q)
        HUNT: if (vs_fall) begin
          state_d = MEASURE;
          good_d  = '0;
        end
        MEASURE: if (vs_fall) begin
          if (frame_ok) begin
            good_d = good_inc;
            if (good_inc >= 4'(LOCK_FRAMES)) state_d = LOCKED;
          end else begin
            good_d = '0;
          end
        end
        LOCKED: if (line_bad || (vs_fall && !frame_ok)) begin
          state_d = MEASURE;
          good_d  = '0;
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // Every exit from LOCKED, whatever the cause, is reported as one error pulse.
  always_comb begin
    locked_d = (state_d == LOCKED);
    terr_d   = (state_q == LOCKED) && (state_d != LOCKED);
  end

  always_ff @(posedge vga_clock or posedge reset) begin
    if (reset) begin
      in_hs_q    <= 1'b1;  in_vs_q    <= 1'b1;  in_blank_q  <= 1'b0;
      dly_hs_q   <= 1'b1;  dly_vs_q   <= 1'b1;  dly_blank_q <= 1'b0;
      x_q        <= '0;    y_q        <= '0;    pv_q        <= 1'b0;
      fs_q       <= 1'b0;  locked_q   <= 1'b0;  terr_q      <= 1'b0;
      act_q      <= '0;    line_act_q <= '0;    vact_q      <= '0;
      h_active_q <= '0;    v_active_q <= '0;    gap_q       <= '0;
      h_ok_q     <= 1'b0;
    end else begin
      in_hs_q    <= in_hs_d;    in_vs_q    <= in_vs_d;    in_blank_q  <= in_blank_d;
      dly_hs_q   <= dly_hs_d;   dly_vs_q   <= dly_vs_d;   dly_blank_q <= dly_blank_d;
      x_q        <= x_d;        y_q        <= y_d;        pv_q        <= pv_d;
      fs_q       <= fs_d;       locked_q   <= locked_d;   terr_q      <= terr_d;
      act_q      <= act_d;      line_act_q <= line_act_d; vact_q      <= vact_d;
      h_active_q <= h_active_d; v_active_q <= v_active_d; gap_q       <= gap_d;
      h_ok_q     <= h_ok_d;
    end
  end

`ifdef VGA_SYNC_DECODER_STATS_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (terr_d && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge vga_clock or posedge reset) begin
    if (reset) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

  assign xCoord      = x_q;
  assign yCoord      = y_q;
  assign pixel_valid = pv_q;
  assign frame_start = fs_q;
  assign locked      = locked_q;
  assign timing_err  = terr_q;
  assign h_total     = h_period;
  assign v_total     = v_period;
  assign h_active    = h_active_q;
  assign v_active    = v_active_q;

endmodule
